// File: rtl/aska_npg_cfg_rx.sv
// ---------------------------------------------------------------------------
// aska_npg_cfg_rx
//
// Serial configuration receiver that sits in front of the ASKA neural pulse
// generator. It takes 72-bit frames (64-bit parameter payload followed by a
// CRC-8) over a 3-wire link, MSB first. A frame is validated for length, CRC
// and parameter ranges. If it passes, the complete parameter bus is updated
// in a single clk cycle. A rejected frame leaves every parameter output as
// it was.
//
// Ports
//   clk            system clock
//   reset          asynchronous reset, active-high
//   s_clk          serial clock (asynchronous to clk); data sampled on its rise
//   s_cs_n         frame select, active-low, held low for the whole frame
//   s_data         serial data, MSB first
//   amplitude .. enable   parameter bus to aska_npg, updated atomically
//   cfg_valid      sticky: set by the first successful commit
//   frame_ok       1-cycle pulse in the cycle the parameter bus updates
//   frame_err      1-cycle pulse when a frame is rejected
//   err_code       00 none, 01 length, 10 CRC, 11 range; held until next commit
// ---------------------------------------------------------------------------
module aska_npg_cfg_rx #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  CRC_POLY    = 8'h07,
    parameter int          AMP_MAX     = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_clk,
    input  logic        s_cs_n,
    input  logic        s_data,
    output logic [5:0]  amplitude,
    output logic [11:0] freq,
    output logic [2:0]  phaseDuration,
    output logic [5:0]  ramp,
    output logic [9:0]  ramp_factor,
    output logic [7:0]  ON_time,
    output logic [9:0]  OFF_time,
    output logic [3:0]  electrode1,
    output logic [3:0]  electrode2,
    output logic        enable,
    output logic        cfg_valid,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code
);

    localparam logic [5:0] AMP_MAX_C  = 6'(AMP_MAX);
    localparam logic [6:0] FRAME_BITS = 7'd72;
    localparam logic [6:0] CNT_SAT    = 7'd73;
    localparam logic [6:0] CRC_BITS   = 7'd64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        CHECK  = 3'd2,
        COMMIT = 3'd3,
        ERROR  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    // The s_cs_n chain resets to 0 (not the idle level 1). If reset is
    // released while a frame is still selected, no falling edge is seen,
    // so the remainder of that interrupted frame is ignored.
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q,   cs_prev_d;

    logic sclk_s, cs_s, data_s;
    logic sclk_rise, cs_fall, cs_rise;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], s_clk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   s_cs_n};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], s_data};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            data_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            data_sync_q <= data_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame datapath
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [71:0] shreg_q, shreg_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  crc_q, crc_d;
    logic [63:0] params_q, params_d;
    logic        cfg_valid_q, cfg_valid_d;
    logic [1:0]  err_code_q, err_code_d;

    logic [63:0] payload;
    logic [7:0]  crc_next;
    logic        crc_fb;
    logic        range_bad;
    logic [1:0]  chk_err;

    assign payload = shreg_q[71:8];

    // Serial CRC-8, MSB first, init 0
    assign crc_fb   = crc_q[7] ^ data_s;
    assign crc_next = {crc_q[6:0], 1'b0} ^ (crc_fb ? CRC_POLY : 8'h00);

    // Range checks on the received payload
    always_comb begin
        range_bad = 1'b0;
        if (payload[63:58] > AMP_MAX_C)        range_bad = 1'b1;
        if (payload[57:46] == 12'd0)           range_bad = 1'b1;
        if (payload[45:43] == 3'd0)            range_bad = 1'b1;
        if (payload[8:5] == payload[4:1])      range_bad = 1'b1;
    end

    // Checks in priority order: length, CRC, range
    always_comb begin
        chk_err = 2'b00;
        if (bit_cnt_q != FRAME_BITS)       chk_err = 2'b01;
        else if (crc_q != shreg_q[7:0])    chk_err = 2'b10;
        else if (range_bad)                chk_err = 2'b11;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = CHECK;
            CHECK:   state_d = (chk_err == 2'b00) ? COMMIT : ERROR;
            COMMIT:  state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        frame_ok  = (state_q == COMMIT);
        frame_err = (state_q == ERROR);
    end

    // Datapath next values. The parameter bus is loaded on the edge that
    // enters COMMIT, so it is already visible while frame_ok is high.
    always_comb begin
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        crc_d       = crc_q;
        params_d    = params_q;
        cfg_valid_d = cfg_valid_q;
        err_code_d  = err_code_q;
        case (state_q)
            IDLE: begin
                shreg_d   = '0;
                bit_cnt_d = '0;
                crc_d     = '0;
            end
            SHIFT: begin
                // An s_clk rise coinciding with the end of frame is dropped
                if (sclk_rise && !cs_rise) begin
                    shreg_d = {shreg_q[70:0], data_s};
                    if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 7'd1;
                    // Only the 64 payload bits feed the CRC
                    if (bit_cnt_q < CRC_BITS) crc_d = crc_next;
                end
            end
            CHECK: begin
                if (chk_err == 2'b00) begin
                    params_d    = payload;
                    cfg_valid_d = 1'b1;
                    err_code_d  = 2'b00;
                end else begin
                    err_code_d  = chk_err;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            crc_q       <= '0;
            params_q    <= '0;
            cfg_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            crc_q       <= crc_d;
            params_q    <= params_d;
            cfg_valid_q <= cfg_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign amplitude     = params_q[63:58];
    assign freq          = params_q[57:46];
    assign phaseDuration = params_q[45:43];
    assign ramp          = params_q[42:37];
    assign ramp_factor   = params_q[36:27];
    assign ON_time       = params_q[26:19];
    assign OFF_time      = params_q[18:9];
    assign electrode1    = params_q[8:5];
    assign electrode2    = params_q[4:1];
    assign enable        = params_q[0];
    assign cfg_valid     = cfg_valid_q;
    assign err_code      = err_code_q;

endmodule

// File: tb/tb_aska_npg_cfg_rx.sv
// ---------------------------------------------------------------------------
// tb_aska_npg_cfg_rx
//
// Drives serial frames into aska_npg_cfg_rx. Every frame sent pushes its
// expected outcome (accept/reject, err_code, parameter bus, cfg_valid) onto
// a scoreboard queue, computed from a reference CRC (polynomial long
// division) and the range rules. When the receiver pulses frame_ok or
// frame_err the oldest entry is popped and compared.
// ---------------------------------------------------------------------------
module tb_aska_npg_cfg_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_clk = 1'b0;
    logic        s_cs_n = 1'b1;
    logic        s_data = 1'b0;
    logic [5:0]  amplitude;
    logic [11:0] freq;
    logic [2:0]  phaseDuration;
    logic [5:0]  ramp;
    logic [9:0]  ramp_factor;
    logic [7:0]  ON_time;
    logic [9:0]  OFF_time;
    logic [3:0]  electrode1;
    logic [3:0]  electrode2;
    logic        enable;
    logic        cfg_valid;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;

    aska_npg_cfg_rx #(
        .SYNC_STAGES (2),
        .CRC_POLY    (8'h07),
        .AMP_MAX     (50)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_clk         (s_clk),
        .s_cs_n        (s_cs_n),
        .s_data        (s_data),
        .amplitude     (amplitude),
        .freq          (freq),
        .phaseDuration (phaseDuration),
        .ramp          (ramp),
        .ramp_factor   (ramp_factor),
        .ON_time       (ON_time),
        .OFF_time      (OFF_time),
        .electrode1    (electrode1),
        .electrode2    (electrode2),
        .enable        (enable),
        .cfg_valid     (cfg_valid),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    logic [63:0] dut_params;
    assign dut_params = {amplitude, freq, phaseDuration, ramp, ramp_factor,
                         ON_time, OFF_time, electrode1, electrode2, enable};

    typedef struct {
        bit          ok;
        logic [1:0]  err;
        logic [63:0] params;
        bit          cfg_valid;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] model_params = '0;
    bit          model_cfg_valid = 1'b0;
    logic [1:0]  model_err = 2'b00;

    int check_cnt = 0;
    int pass_cnt  = 0;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [63:0] pack(input int amp, input int fr, input int pd,
                                         input int rp, input int rf, input int on_t,
                                         input int off_t, input int e1, input int e2,
                                         input int en);
        return {6'(amp), 12'(fr), 3'(pd), 6'(rp), 10'(rf), 8'(on_t), 10'(off_t),
                4'(e1), 4'(e2), 1'(en)};
    endfunction

    // CRC-8 as the remainder of {payload, 8'h00} divided by x^8+x^2+x+1
    function automatic logic [7:0] crc_model(input logic [63:0] p);
        logic [71:0] r;
        r = {p, 8'h00};
        for (int i = 71; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        end
        return r[7:0];
    endfunction

    function automatic bit range_ok(input logic [63:0] p);
        return (p[63:58] <= 6'd50) && (p[57:46] != 12'd0) &&
               (p[45:43] != 3'd0) && (p[8:5] != p[4:1]);
    endfunction

    task automatic push_expect(input logic [63:0] p, input logic [7:0] crc, input int n);
        exp_t e;
        logic [1:0] code;
        if (n != 72)                   code = 2'b01;
        else if (crc != crc_model(p))  code = 2'b10;
        else if (!range_ok(p))         code = 2'b11;
        else                           code = 2'b00;
        if (code == 2'b00) begin
            model_params    = p;
            model_cfg_valid = 1'b1;
        end
        model_err   = code;
        e.ok        = (code == 2'b00);
        e.err       = code;
        e.params    = model_params;
        e.cfg_valid = model_cfg_valid;
        sb_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Serial link driver
    // ------------------------------------------------------------------
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        s_clk  = 1'b0;
        s_cs_n = 1'b0;
        wait_clks(3);
    endtask

    task automatic send_bits(input logic [79:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            s_data = bits[i];
            wait_clks(3);
            s_clk = 1'b1;
            wait_clks(3);
            s_clk = 1'b0;
        end
    endtask

    task automatic end_frame();
        wait_clks(3);
        s_cs_n = 1'b1;
    endtask

    // Sends n bits taken from the 72-bit frame {p, crc}: fewer bits drop the
    // tail, extra bits append zeros.
    task automatic send_frame(input logic [63:0] p, input logic [7:0] crc, input int n);
        logic [79:0] bits;
        bits = {8'h00, p, crc};
        if (n < 72) bits = bits >> (72 - n);
        else        bits = bits << (n - 72);
        push_expect(p, crc, n);
        start_frame();
        send_bits(bits, n);
        end_frame();
    endtask

    // Waits for the receiver's verdict on the frame just closed and scores it
    task automatic collect(input string name);
        int   lat;
        bit   seen;
        exp_t e;
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (frame_ok || frame_err) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
        end
        check_cnt++;
        if (!seen) begin
            $display("FAIL %s timeout: no frame_ok/frame_err within 20 cycles", name);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        pass_cnt++;
        check_cnt++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s unexpected verdict: scoreboard empty", name);
            return;
        end
        pass_cnt++;
        e = sb_q.pop_front();

        check_cnt++;
        if (lat !== 4) $display("FAIL %s latency: got %0d cycles, want 4", name, lat);
        else pass_cnt++;

        check_cnt++;
        if ({frame_ok, frame_err} !== {e.ok, ~e.ok})
            $display("FAIL %s verdict: ok/err got %b%b, want %b%b", name, frame_ok, frame_err,
                     e.ok, ~e.ok);
        else pass_cnt++;

        check_cnt++;
        if (err_code !== e.err) $display("FAIL %s err_code: got %b, want %b", name, err_code, e.err);
        else pass_cnt++;

        check_cnt++;
        if (dut_params !== e.params)
            $display("FAIL %s params: got %h, want %h", name, dut_params, e.params);
        else pass_cnt++;

        check_cnt++;
        if (cfg_valid !== e.cfg_valid)
            $display("FAIL %s cfg_valid: got %b, want %b", name, cfg_valid, e.cfg_valid);
        else pass_cnt++;

        wait_clks(1);
        check_cnt++;
        if ({frame_ok, frame_err} !== 2'b00)
            $display("FAIL %s pulse width: ok/err still %b%b one cycle later", name, frame_ok,
                     frame_err);
        else pass_cnt++;

        $display("frame %-14s ok=%b err=%b err_code=%b params=%h cfg_valid=%b", name,
                 e.ok, ~e.ok, err_code, dut_params, cfg_valid);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    logic [63:0] legal1;
    logic [63:0] legal2;

    task automatic test_reset();
        check_cnt++;
        if ({dut_params, cfg_valid, frame_ok, frame_err, err_code} !== 69'd0)
            $display("FAIL reset_state: params=%h cfg_valid=%b ok=%b err=%b err_code=%b, want all 0",
                     dut_params, cfg_valid, frame_ok, frame_err, err_code);
        else pass_cnt++;
        $display("reset state params=%h cfg_valid=%b err_code=%b", dut_params, cfg_valid, err_code);
    endtask

    task automatic test_legal_frame();
        send_frame(legal1, crc_model(legal1), 72);
        collect("legal");
    endtask

    task automatic test_crc_error();
        send_frame(legal1, crc_model(legal1) ^ 8'h01, 72);
        collect("crc_flip");
    endtask

    task automatic test_all_zero();
        send_frame(64'd0, 8'h00, 72);
        collect("all_zero");
    endtask

    task automatic test_length();
        send_frame(legal1, crc_model(legal1), 71);
        collect("len71");
        send_frame(legal1, crc_model(legal1), 73);
        collect("len73");
    endtask

    task automatic test_reset_midframe();
        logic [79:0] bits;
        bit          pulse;
        bits = {8'h00, legal2, crc_model(legal2)};
        start_frame();
        send_bits(bits >> 32, 40);
        reset = 1'b1;
        #2;
        check_cnt++;
        if ({dut_params, cfg_valid, err_code} !== 67'd0)
            $display("FAIL midframe_reset: params=%h cfg_valid=%b err_code=%b, want all 0",
                     dut_params, cfg_valid, err_code);
        else pass_cnt++;
        model_params    = '0;
        model_cfg_valid = 1'b0;
        model_err       = 2'b00;
        wait_clks(2);
        reset = 1'b0;
        send_bits(bits, 32);
        end_frame();
        pulse = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (frame_ok || frame_err) pulse = 1'b1;
        end
        check_cnt++;
        if (pulse || dut_params !== 64'd0 || cfg_valid !== 1'b0)
            $display("FAIL aborted_frame: pulse=%b params=%h cfg_valid=%b, want 0/0/0",
                     pulse, dut_params, cfg_valid);
        else pass_cnt++;
        $display("aborted frame pulse=%b params=%h cfg_valid=%b", pulse, dut_params, cfg_valid);
        send_frame(legal2, crc_model(legal2), 72);
        collect("after_reset");
    endtask

    task automatic test_range();
        logic [63:0] p;
        p = pack(51, 400, 4, 10, 16, 50, 50, 4, 1, 1);
        send_frame(p, crc_model(p), 72);
        collect("amp51");
        p = pack(10, 400, 4, 10, 16, 50, 50, 3, 3, 1);
        send_frame(p, crc_model(p), 72);
        collect("e1_eq_e2");
        p = pack(10, 400, 0, 10, 16, 50, 50, 4, 1, 1);
        send_frame(p, crc_model(p), 72);
        collect("pd0");
        // Boundary amplitude with enable=0 is still a legal, committing frame
        p = pack(50, 4095, 7, 63, 1023, 255, 1023, 15, 0, 0);
        send_frame(p, crc_model(p), 72);
        collect("amp50_en0");
    endtask

    task automatic test_back_to_back();
        logic [63:0] p;
        for (int k = 0; k < 3; k++) begin
            p = pack($urandom_range(0, 50), $urandom_range(1, 4095), $urandom_range(1, 7),
                     $urandom_range(0, 63), $urandom_range(0, 1023), $urandom_range(0, 255),
                     $urandom_range(0, 1023), 2 * k, 2 * k + 1, k % 2);
            send_frame(p, crc_model(p), 72);
            collect("back_to_back");
        end
    endtask

    initial begin
        legal1 = pack(10, 400, 4, 10, 16, 50, 50, 4, 1, 1);
        legal2 = pack(20, 1000, 2, 5, 100, 20, 80, 2, 7, 1);
        reset  = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(3);

        test_reset();
        test_legal_frame();
        test_crc_error();
        test_all_zero();
        test_length();
        test_reset_midframe();
        test_range();
        test_back_to_back();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
